// File: rtl/registers_bank_dumper.sv
// Snapshots a flat register debug bus and streams it out one byte per valid/ready beat.
// Optional macro REGS_DUMP_HEADER_EN prefixes each dump with header byte 8'hA5.
module registers_bank_dumper #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_start,
    input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
    input  logic                                        i_ready,
    output logic [7:0]                                  o_data,
    output logic                                        o_valid,
    output logic                                        o_busy,
    output logic                                        o_done,
    output logic [1:0]                                  o_dbg_state
);

    localparam int TOTAL_BITS    = REGISTERS_BANK_SIZE * REGISTERS_SIZE;
    localparam int BYTES_PER_REG = REGISTERS_SIZE / 8;
    localparam int BYTE_W        = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam int REG_W         = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_REG - 1);
    localparam logic [REG_W-1:0]  LAST_REG  = REG_W'(REGISTERS_BANK_SIZE - 1);
    localparam logic [7:0]        HEADER_BYTE = 8'hA5;

`ifdef REGS_DUMP_HEADER_EN
    localparam logic HEADER_EN = 1'b1;
`else
    localparam logic HEADER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Handshake: a byte moves on a rising edge where o_valid and i_ready are both 1;
    // o_valid never drops and o_data never changes until that byte has moved.
    state_e                  state_q, state_d;
    logic [TOTAL_BITS-1:0]   snap_q, snap_d;
    logic [BYTE_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [REG_W-1:0]        reg_cnt_q, reg_cnt_d;
    logic                    hdr_q, hdr_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            byte_cnt_q <= '0;
            reg_cnt_q  <= '0;
            hdr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            byte_cnt_q <= byte_cnt_d;
            reg_cnt_q  <= reg_cnt_d;
            hdr_q      <= hdr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        byte_cnt_d = byte_cnt_q;
        reg_cnt_d  = reg_cnt_q;
        hdr_d      = hdr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    snap_d     = i_bus_debug;
                    byte_cnt_d = '0;
                    reg_cnt_d  = '0;
                    hdr_d      = HEADER_EN;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                    end else begin
                        // The snapshot shifts down so the current byte is always bits [7:0].
                        snap_d = snap_q >> 8;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            if (reg_cnt_q == LAST_REG) begin
                                reg_cnt_d = '0;
                                state_d   = ST_DONE;
                            end else begin
                                reg_cnt_d = reg_cnt_q + REG_W'(1);
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_valid     = (state_q == ST_SEND);
        o_busy      = (state_q == ST_SEND);
        o_done      = (state_q == ST_DONE);
        o_dbg_state = state_q;
        o_data      = 8'h00;
        if (state_q == ST_SEND) begin
            o_data = hdr_q ? HEADER_BYTE : snap_q[7:0];
        end
    end

endmodule

// File: tb/tb_registers_bank_dumper.sv
// Self-checking bench for registers_bank_dumper: table of dump scenarios checked against a byte-list model.
module tb_registers_bank_dumper;

    localparam int BANK = 4;
    localparam int RSIZE = 32;
    localparam int NB = BANK * RSIZE / 8;
`ifdef REGS_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int EXP_BYTES = NB + HDR;
    localparam logic [127:0] SPEC_BUS = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11223344};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    logic [127:0] bus = '0;
    logic [7:0]   o_data;
    logic         o_valid, o_busy, o_done;
    logic [1:0]   o_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] recv_q[$];

    typedef struct {
        logic [127:0] bus;
        int           mode;      // 0: ready driven by stall window, 1: random ready
        int           stall_at;
        int           stall_len;
        bit           chg;
        bit           restart;
        int           exp_bytes;
    } dump_vec_t;

    dump_vec_t tbl[5];

    registers_bank_dumper #(
        .REGISTERS_BANK_SIZE(BANK),
        .REGISTERS_SIZE(RSIZE)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_start(start),
        .i_bus_debug(bus),
        .i_ready(ready),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Model: header (if enabled), then each register LSB byte first, registers in index order.
    function automatic void build_model(input logic [127:0] b);
        exp_q.delete();
        if (HDR == 1) exp_q.push_back(8'hA5);
        for (int r = 0; r < BANK; r++)
            for (int k = 0; k < RSIZE / 8; k++)
                exp_q.push_back(b[r*RSIZE + 8*k +: 8]);
    endfunction

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, {31'd0, o_valid}, 32'd0);
        check({name, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({name, "_done"}, {31'd0, o_done}, 32'd0);
        check({name, "_data"}, {24'd0, o_data}, 32'd0);
    endtask

    task automatic run_dump(input dump_vec_t v);
        int  got;
        int  stalled;
        int  idle_valid;
        bit  finished;
        build_model(v.bus);
        recv_q.delete();
        got = 0;
        stalled = 0;
        finished = 1'b0;
        @(negedge clk);
        bus = v.bus;
        start = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("first_valid", {31'd0, o_valid}, 32'd1);
        check("first_busy", {31'd0, o_busy}, 32'd1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (v.mode == 1) ready = 1'($urandom_range(0, 1));
            else ready = !(got == v.stall_at && stalled < v.stall_len);
            if (v.chg && got >= 1) bus = '1;
            start = v.restart && (got == 5);
            #1;
            if (!o_valid) begin
                finished = 1'b1;
            end else begin
                if (got < EXP_BYTES) check("byte", {24'd0, o_data}, {24'd0, exp_q[got]});
                else check("extra_byte", got, EXP_BYTES - 1);
                check("busy_in_send", {31'd0, o_busy}, 32'd1);
                if (!ready) stalled++;
                else begin
                    recv_q.push_back(o_data);
                    got++;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!finished) check("timeout", 32'd0, 32'd1);
        check("byte_count", got, v.exp_bytes);
        if (v.mode == 0) check("stall_cycles", stalled, v.stall_len);
        check("done_pulse", {31'd0, o_done}, 32'd1);
        check("done_busy", {31'd0, o_busy}, 32'd0);
        check("done_data", {24'd0, o_data}, 32'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        idle_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (o_valid || o_done) idle_valid++;
        end
        check("no_restart", idle_valid, 0);
    endtask

    initial begin
        logic [7:0] hand[8];
        logic [7:0] first_exp;
        hand = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        first_exp = (HDR == 1) ? 8'hA5 : 8'h44;
        void'($urandom(616563));

        tbl[0] = '{bus: SPEC_BUS, mode: 0, stall_at: 0, stall_len: 0, chg: 0, restart: 0, exp_bytes: EXP_BYTES};
        tbl[1] = '{bus: SPEC_BUS, mode: 0, stall_at: 2 + HDR, stall_len: 5, chg: 0, restart: 0, exp_bytes: EXP_BYTES};
        tbl[2] = '{bus: SPEC_BUS, mode: 0, stall_at: 0, stall_len: 0, chg: 1, restart: 1, exp_bytes: EXP_BYTES};
        tbl[3] = '{bus: SPEC_BUS, mode: 1, stall_at: 0, stall_len: 0, chg: 0, restart: 0, exp_bytes: EXP_BYTES};
        tbl[4] = '{bus: {$urandom, $urandom, $urandom, $urandom}, mode: 1, stall_at: 0, stall_len: 0,
                   chg: 0, restart: 1, exp_bytes: EXP_BYTES};

        // Reset state
        #1;
        check_idle_outputs("reset");
        check("reset_state", {30'd0, o_dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            run_dump(tbl[t]);
            if (recv_q.size() > 0) check("first_byte", {24'd0, recv_q[0]}, {24'd0, (t == 4) ? exp_q[0] : first_exp});
            if (t == 0 && recv_q.size() >= 8 + HDR)
                for (int i = 0; i < 8; i++) check("spec_byte", {24'd0, recv_q[HDR + i]}, {24'd0, hand[i]});
        end

        // Reset mid-dump after byte 7, then a fresh dump from register 0 byte 0
        begin
            int got;
            got = 0;
            @(negedge clk);
            bus = SPEC_BUS;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            ready = 1'b1;
            for (int cyc = 0; cyc < 50 && got < 7; cyc++) begin
                #1;
                if (o_valid) got++;
                @(negedge clk);
            end
            check("pre_reset_bytes", got, 7);
            rst_n = 1'b0;
            #1;
            check_idle_outputs("mid_reset");
            @(negedge clk);
            @(negedge clk);
            #1;
            check_idle_outputs("held_reset");
            rst_n = 1'b1;
            ready = 1'b0;
            @(negedge clk);
            #1;
            check_idle_outputs("after_reset");
            run_dump(tbl[0]);
            if (recv_q.size() > HDR) check("restart_first_data", {24'd0, recv_q[HDR]}, 32'h44);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
